alu_parity_pipe: RTL and testbench
==================================

Name: alu_parity_pipe

Overview:
- Parametrised 3-stage elastic ALU pipeline: one-hot 8-bit instruction select, two WIDTH-bit operands, result plus parity.
- Stages: S1 decode/operand latch, S2 execute, S3 parity/flag.
- Valid/ready handshake on both sides gives full backpressure.
- Adds illegal-instruction detection, selectable parity sense and a retired-op counter.

Parameters:
- WIDTH, 4, operand/result width (>=2).
- CNT_W, 8, width of the retired-op counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  inst/a/b valid this cycle.
- in_ready  output  1  pipeline accepts input this cycle.
- inst  input  8  one-hot opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- odd_mode  input  1  parity sense; sampled with the op at S1.
- out_valid  output  1  S3 holds a result.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  ALU result.
- carry  output  1  ADD carry-out / SUB borrow; 0 for logic ops.
- parity  output  1  parity bit over result.
- illegal  output  1  op was not one-hot.
- retired  output  CNT_W  count of results consumed (out_valid & out_ready).

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, so out_valid=0. result, carry, parity, illegal = 0. retired = 0. in_ready=1 on the first cycle after release.
- Handshake per stage k (k=1..3):
  - ready_k = !v_k | ready_{k+1}; ready_4 = out_ready; in_ready = ready_1 (combinational chain).
  - Stage k loads when ready_k. It loads v_{k-1} (v_0 = in_valid) and the payload.
  - Payload is held while v_k & !ready_{k+1}.
  - Bubbles collapse: an empty stage never blocks.
- Latency: 3 cycles from the accept edge to out_valid when out_ready is held 1. Throughput 1 op/cycle.
- S1: register a, b, odd_mode. Decode inst to ctrl:
  - 8'h01 ADD, 8'h02 SUB, 8'h04 XOR, 8'h08 OR, 8'h10 AND, 8'h20 NOR, 8'h40 NAND, 8'h80 XNOR.
  - Zero or multi-hot sets the illegal bit.
- S2 execute:
  - ADD: {carry,result} = a + b, computed at WIDTH+1 bits.
  - SUB: result = a - b modulo 2^WIDTH; carry = 1 iff a < b (unsigned borrow).
  - Logic ops: bitwise on WIDTH bits; carry = 0.
  - Illegal: result = 0, carry = 0.
- S3: parity = ^result XOR odd_mode.
  - odd_mode=0: result plus parity has an even number of ones.
  - odd_mode=1: odd number of ones.
  - Carry is excluded from parity. illegal is passed through.
- Outputs are registered in S3 and stay stable while out_valid & !out_ready.
- retired increments on each out_valid & out_ready. It wraps from 2^CNT_W-1 to 0. Illegal ops count as retired.
- A new input accepted in the same cycle S3 drains moves through without a lost or duplicated op.
- in_valid=0 inserts a bubble; no stage changes state for invalid slots except shifting valid bits.
- Reset mid-operation: all in-flight ops are discarded immediately. No output appears after reset release until new ops are accepted.
- inst, a and b are don't-care when in_valid=0.

Test Plan:
- WIDTH=4, a=1100, b=1010, odd_mode=0, out_ready=1; issue 01,02,04,08,10,20,40,80 back-to-back. Required results, one per cycle from cycle 3:
  - 01 ADD: 0110 c1 p0
  - 02 SUB: 0010 c0 p1
  - 04 XOR: 0110 p0
  - 08 OR: 1110 p1
  - 10 AND: 1000 p1
  - 20 NOR: 0001 p1
  - 40 NAND: 0111 p1
  - 80 XNOR: 1001 p0
  - retired=8 at end.
- Same a/b, op 01, odd_mode=1 -> result 0110, parity 1.
- SUB with a=0011, b=0101 -> result 1110, carry 1, parity 1.
- inst=8'h00 then 8'h03 -> result 0000, carry 0, illegal 1 for both, parity 0. retired increments by 2.
- Backpressure:
  - Stream 5 ops with out_ready=0 -> in_ready drops after 3 accepts; out_valid held with stable payload.
  - Raise out_ready -> all 5 emerge in order, no loss or duplication.
- Reset:
  - Assert rst_n=0 between clock edges with 3 ops in flight -> out_valid and retired go to 0 at once.
  - After release, the first output appears exactly 3 cycles after the next accept.

Source files
------------

// File: rtl/alu_parity_pipe.sv
// Three-stage elastic ALU: S1 decode/latch, S2 execute, S3 parity/flags.
// Each stage carries a valid bit and is chained on ready for full backpressure.
module alu_parity_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       inst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             parity,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    OpAdd, OpSub, OpXor, OpOr, OpAnd, OpNor, OpNand, OpXnor
  } op_e;

  logic ready1, ready2, ready3;

  // S1 state
  logic             v1_q;
  op_e              op1_q;
  logic             ill1_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic             odd1_q;

  // S2 state
  logic             v2_q;
  logic [WIDTH-1:0] res2_q;
  logic             cy2_q, ill2_q, odd2_q;

  // S3 state
  logic             v3_q;
  logic [WIDTH-1:0] res3_q;
  logic             cy3_q, par3_q, ill3_q;

  logic [CNT_W-1:0] retired_q;

  // Empty stages always accept, so bubbles collapse.
  assign ready3   = !v3_q || out_ready;
  assign ready2   = !v2_q || ready3;
  assign ready1   = !v1_q || ready2;
  assign in_ready = ready1;

  op_e  dec_op;
  logic dec_ill;

  always_comb begin
    dec_op  = OpAdd;
    dec_ill = 1'b0;
    unique case (inst)
      8'h01:   dec_op = OpAdd;
      8'h02:   dec_op = OpSub;
      8'h04:   dec_op = OpXor;
      8'h08:   dec_op = OpOr;
      8'h10:   dec_op = OpAnd;
      8'h20:   dec_op = OpNor;
      8'h40:   dec_op = OpNand;
      8'h80:   dec_op = OpXnor;
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      op1_q  <= OpAdd;
      ill1_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      odd1_q <= 1'b0;
    end else if (ready1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        op1_q  <= dec_op;
        ill1_q <= dec_ill;
        a1_q   <= a;
        b1_q   <= b;
        odd1_q <= odd_mode;
      end
    end
  end

  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] res2_d;
  logic             cy2_d;

  // SUB borrow falls out as the top bit of the WIDTH+1 bit difference.
  always_comb begin
    sum_d  = '0;
    res2_d = '0;
    cy2_d  = 1'b0;
    if (!ill1_q) begin
      unique case (op1_q)
        OpAdd: begin
          sum_d  = {1'b0, a1_q} + {1'b0, b1_q};
          res2_d = sum_d[WIDTH-1:0];
          cy2_d  = sum_d[WIDTH];
        end
        OpSub: begin
          sum_d  = {1'b0, a1_q} - {1'b0, b1_q};
          res2_d = sum_d[WIDTH-1:0];
          cy2_d  = sum_d[WIDTH];
        end
        OpXor:  res2_d = a1_q ^ b1_q;
        OpOr:   res2_d = a1_q | b1_q;
        OpAnd:  res2_d = a1_q & b1_q;
        OpNor:  res2_d = ~(a1_q | b1_q);
        OpNand: res2_d = ~(a1_q & b1_q);
        OpXnor: res2_d = ~(a1_q ^ b1_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      res2_q <= '0;
      cy2_q  <= 1'b0;
      ill2_q <= 1'b0;
      odd2_q <= 1'b0;
    end else if (ready2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        res2_q <= res2_d;
        cy2_q  <= cy2_d;
        ill2_q <= ill1_q;
        odd2_q <= odd1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      res3_q <= '0;
      cy3_q  <= 1'b0;
      par3_q <= 1'b0;
      ill3_q <= 1'b0;
    end else if (ready3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        res3_q <= res2_q;
        cy3_q  <= cy2_q;
        par3_q <= (^res2_q) ^ odd2_q;
        ill3_q <= ill2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (v3_q && out_ready) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign out_valid = v3_q;
  assign result    = res3_q;
  assign carry     = cy3_q;
  assign parity    = par3_q;
  assign illegal   = ill3_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_alu_parity_pipe.sv
// Randomised scoreboard bench for alu_parity_pipe: a behavioural model predicts
// every accepted op, results are matched in order as they retire.
module tb_alu_parity_pipe;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    inst = 8'h00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          odd_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          carry, parity, illegal;
  logic [CW-1:0] retired;

  alu_parity_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .a        (a),
    .b        (b),
    .odd_mode (odd_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .parity   (parity),
    .illegal  (illegal),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         p;
    logic         il;
  } out_t;

  int   tests = 0;
  int   fails = 0;
  out_t expq[$];
  out_t got;
  logic fired;
  logic accepted;
  int   exp_ret = 0;

  function automatic out_t model(input logic [7:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic odd);
    out_t        o;
    int unsigned xi, yi, m, r;
    xi = x;
    yi = y;
    m  = 1 << W;
    r  = 0;
    o  = '0;
    if ($countones(op) != 1) begin
      o.il = 1'b1;
    end else begin
      case (op)
        8'h01: begin r = (xi + yi) % m; o.c = (xi + yi) >= m; end
        8'h02: begin r = (xi + m - yi) % m; o.c = xi < yi; end
        8'h04: r = xi ^ yi;
        8'h08: r = xi | yi;
        8'h10: r = xi & yi;
        8'h20: r = (~(xi | yi)) % m;
        8'h40: r = (~(xi & yi)) % m;
        default: r = (~(xi ^ yi)) % m;
      endcase
    end
    o.res = r[W-1:0];
    o.p   = (($countones(o.res) % 2) == 1) ^ odd;
    return o;
  endfunction

  // One clock: observe handshakes mid-cycle, then advance to just after the edge.
  task automatic cycle();
    #3;
    accepted = in_valid && in_ready;
    fired    = out_valid && out_ready;
    got      = {result, carry, parity, illegal};
    if (accepted) expq.push_back(model(inst, a, b, odd_mode));
    if (fired) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic odd);
    in_valid = 1'b1;
    inst     = op;
    a        = x;
    b        = y;
    odd_mode = odd;
  endtask

  // Issue a single op with out_ready=1 and wait (bounded) for it to emerge.
  task automatic one_op(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic odd, output out_t o, output int lat);
    out_ready = 1'b1;
    drive(op, x, y, odd);
    cycle();
    in_valid = 1'b0;
    lat = -1;
    o   = '0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (fired) begin
        lat = i;
        o   = got;
        if (expq.size() > 0) void'(expq.pop_front());
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({out_valid, result, carry, parity, illegal, retired} !== '0) begin
      fails++;
      $display("FAIL reset_state: got ov=%b res=%h c=%b p=%b il=%b ret=%0d expected all 0",
               out_valid, result, carry, parity, illegal, retired);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] tbl [8];
    int           k, first_at;
    logic [CW-1:0] base;
    tbl = '{7'b0110100, 7'b0010010, 7'b0110000, 7'b1110010,
            7'b1000010, 7'b0001010, 7'b0111010, 7'b1001000};
    base      = retired;
    out_ready = 1'b1;
    k         = 0;
    first_at  = -1;
    for (int it = 0; it < 11; it++) begin
      if (it < 8) drive(8'(1 << it), 4'b1100, 4'b1010, 1'b0);
      else in_valid = 1'b0;
      cycle();
      if (fired) begin
        if (first_at < 0) first_at = it;
        tests++;
        if (expq.size() == 0 || k >= 8) begin
          fails++;
          $display("FAIL b2b_spurious: got output %h at iter %0d expected none", got, it);
        end else begin
          void'(expq.pop_front());
          if (got !== out_t'(tbl[k])) begin
            fails++;
            $display("FAIL b2b_op%0d: got %b expected %b", k, got, tbl[k]);
          end
        end
        k++;
      end
    end
    tests++;
    if (first_at != 3 || k != 8) begin
      fails++;
      $display("FAIL b2b_timing: got first=%0d count=%0d expected first=3 count=8", first_at, k);
    end
    tests++;
    if (retired !== CW'(base + 8)) begin
      fails++;
      $display("FAIL b2b_retired: got %0d expected %0d", retired, CW'(base + 8));
    end
  endtask

  task automatic test_odd_and_borrow();
    out_t o;
    int   lat;
    one_op(8'h01, 4'b1100, 4'b1010, 1'b1, o, lat);
    tests++;
    if (o !== {4'b0110, 1'b1, 1'b1, 1'b0} || lat != 3) begin
      fails++;
      $display("FAIL odd_parity: got %b lat %0d expected 0110110 lat 3", o, lat);
    end
    one_op(8'h02, 4'b0011, 4'b0101, 1'b0, o, lat);
    tests++;
    if (o !== {4'b1110, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL sub_borrow: got %b expected 1110110", o);
    end
  endtask

  task automatic test_illegal();
    out_t          o;
    int            lat;
    logic [CW-1:0] base;
    logic [7:0]    ops [2];
    ops  = '{8'h00, 8'h03};
    base = retired;
    for (int i = 0; i < 2; i++) begin
      one_op(ops[i], 4'($urandom), 4'($urandom), 1'b0, o, lat);
      tests++;
      if (o !== {4'b0000, 1'b0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL illegal_%h: got %b expected 0000001", ops[i], o);
      end
    end
    tests++;
    if (retired !== CW'(base + 2)) begin
      fails++;
      $display("FAIL illegal_retired: got %0d expected %0d", retired, CW'(base + 2));
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]   op [5];
    logic [W-1:0] xa [5];
    logic [W-1:0] xb [5];
    int           acc, nout;
    out_t         snap;
    for (int i = 0; i < 5; i++) begin
      op[i] = 8'(1 << $urandom_range(0, 7));
      xa[i] = 4'($urandom);
      xb[i] = 4'($urandom);
    end
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(op[acc], xa[acc], xb[acc], acc[0]);
      cycle();
      if (accepted) acc++;
    end
    tests++;
    if (acc != 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_fill: got acc=%0d in_ready=%b out_valid=%b expected 3 0 1",
               acc, in_ready, out_valid);
    end
    snap = {result, carry, parity, illegal};
    tests++;
    if (expq.size() == 0 || snap !== expq[0]) begin
      fails++;
      $display("FAIL bp_head: got %b expected %b", snap, expq.size() ? expq[0] : out_t'('0));
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (got !== snap || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold: got %b ov=%b expected %b ov=1", got, out_valid, snap);
      end
    end
    out_ready = 1'b1;
    nout = 0;
    for (int i = 0; i < 20; i++) begin
      if (acc < 5) drive(op[acc], xa[acc], xb[acc], acc[0]);
      else in_valid = 1'b0;
      cycle();
      if (accepted) acc++;
      if (fired) begin
        nout++;
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL bp_drain: got extra output %b expected none", got);
        end else begin
          snap = expq.pop_front();
          if (got !== snap) begin
            fails++;
            $display("FAIL bp_drain: got %b expected %b", got, snap);
          end
        end
      end
    end
    tests++;
    if (nout != 5 || acc != 5) begin
      fails++;
      $display("FAIL bp_count: got out=%0d acc=%0d expected 5 5", nout, acc);
    end
  endtask

  task automatic test_random();
    out_t e;
    for (int it = 0; it < 420; it++) begin
      if (it < 400) begin
        in_valid = ($urandom_range(0, 3) != 0);
        inst     = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
        a        = 4'($urandom);
        b        = 4'($urandom);
        odd_mode = 1'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      cycle();
      if (fired) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL rand_spurious: got %b expected none", got);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL rand_result: got %b expected %b", got, e);
          end
        end
      end
    end
    tests++;
    if (expq.size() != 0 || retired !== CW'(exp_ret % (1 << CW))) begin
      fails++;
      $display("FAIL rand_retired: got %0d left=%0d expected %0d left=0",
               retired, expq.size(), exp_ret % (1 << CW));
    end
  endtask

  task automatic test_reset_mid();
    out_t o;
    int   lat;
    logic any_out;
    out_ready = 1'b1;
    one_op(8'h04, 4'($urandom), 4'($urandom), 1'b0, o, lat);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'h08, 4'($urandom), 4'($urandom), 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || retired === '0) begin
      fails++;
      $display("FAIL rst_mid_pre: got ov=%b ret=%0d expected ov=1 ret!=0", out_valid, retired);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || retired !== '0) begin
      fails++;
      $display("FAIL rst_mid_clear: got ov=%b ret=%0d expected 0 0", out_valid, retired);
    end
    expq.delete();
    exp_ret = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    any_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (fired) any_out = 1'b1;
    end
    tests++;
    if (any_out !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_ghost: got output after reset expected none");
    end
    one_op(8'h10, 4'b1100, 4'b1010, 1'b0, o, lat);
    tests++;
    if (lat != 3 || o !== {4'b1000, 1'b0, 1'b1, 1'b0} || retired !== 8'd1) begin
      fails++;
      $display("FAIL rst_mid_after: got lat=%0d o=%b ret=%0d expected lat=3 o=1000010 ret=1",
               lat, o, retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_odd_and_borrow();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
